rtc_alarm_core: RTL and testbench

Parametrised timekeeping core for the digital clock: it keeps a BCD time-of-day and calendar date, and compares the time against N programmable alarm channels. Ringing is driven by a ring/snooze state machine with auto-timeout. It replaces the single-alarm time counter and alarm compare path. It feeds the seg7 display mux and the beeper driver, and takes load/ack/snooze strobes from the key/adjust logic.

---
 rtl/rtc_alarm_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_rtc_alarm_core.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alarm_core.sv
// rtc_alarm_core: BCD time-of-day and calendar keeper with N alarm channels
// and a ring/snooze state machine that stops ringing on its own after a timeout.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   load_time, time_wdata   strobe + BCD {hh, mm, ss}; ignored unless valid
//   load_date, date_wdata   strobe + BCD {yy, mm, dd}; ignored unless valid
//   alarm_wr, alarm_idx,
//   alarm_wdata             strobe + channel + {en, hh, mm}; ignored unless valid
//   ack, snooze             strobes from the key logic
//   time_num, date_num      current BCD time / date
//   sec_pulse               one cycle, aligned with the new time value
//   ring, snoozing          high while in RING / SNOOZE
//   ring_idx                channel that started the current RING/SNOOZE
module rtc_alarm_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int AW = $clog2(N_ALARM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_time,
  input  logic [23:0]   time_wdata,
  input  logic          load_date,
  input  logic [23:0]   date_wdata,
  input  logic          alarm_wr,
  input  logic [AW-1:0] alarm_idx,
  input  logic [16:0]   alarm_wdata,
  input  logic          ack,
  input  logic          snooze,
  output logic [23:0]   time_num,
  output logic [23:0]   date_num,
  output logic          sec_pulse,
  output logic          ring,
  output logic          snoozing,
  output logic [AW-1:0] ring_idx
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_FREQ - 1);
  localparam logic [13:0]   RING_LAST   = 14'(RING_SEC - 1);
  localparam logic [13:0]   SNOOZE_LAST = 14'(SNOOZE_MIN * 60 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_e;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Days in month as BCD. yy = 10t + u is a multiple of 4 exactly when
  // (2t + u) mod 4 == 0, so only bit 0 of the tens digit matters.
  function automatic logic [7:0] days_in_month(input logic [7:0] yy, input logic [7:0] mo);
    logic [1:0] r;
    r = yy[1:0] + {yy[4], 1'b0};
    case (mo)
      8'h02:                      return (r == 2'd0) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  logic [PW-1:0]      presc_q, presc_d;
  logic [23:0]        time_q, time_d, date_q, date_d;
  logic               sec_pulse_q, sec_pulse_d;
  logic [N_ALARM-1:0] alarm_en_q, alarm_en_d;
  logic [15:0]        alarm_hm_q [N_ALARM];
  logic [15:0]        alarm_hm_d [N_ALARM];
  state_e             state_q, state_d;
  logic [AW-1:0]      ring_idx_q, ring_idx_d;
  logic [13:0]        sec_cnt_q, sec_cnt_d;

  logic          tick, time_ok, date_ok, alarm_ok, chan_cleared;
  logic          day_carry, match_hit;
  logic [AW-1:0] match_idx;
  logic [23:0]   time_inc, date_inc;

  assign tick = (presc_q == PRESC_LAST);

  assign time_ok = bcd_ok(time_wdata[23:16]) && bcd_ok(time_wdata[15:8]) &&
                   bcd_ok(time_wdata[7:0]) && (time_wdata[23:16] <= 8'h23) &&
                   (time_wdata[15:8] <= 8'h59) && (time_wdata[7:0] <= 8'h59);

  // The year digits are checked too, so the leap-year decode never sees junk.
  assign date_ok = bcd_ok(date_wdata[23:16]) && bcd_ok(date_wdata[15:8]) &&
                   bcd_ok(date_wdata[7:0]) && (date_wdata[15:8] != 8'h00) &&
                   (date_wdata[15:8] <= 8'h12) && (date_wdata[7:0] != 8'h00) &&
                   (date_wdata[7:0] <= days_in_month(date_wdata[23:16], date_wdata[15:8]));

  assign alarm_ok = bcd_ok(alarm_wdata[15:8]) && bcd_ok(alarm_wdata[7:0]) &&
                    (alarm_wdata[15:8] <= 8'h23) && (alarm_wdata[7:0] <= 8'h59) &&
                    (32'(alarm_idx) < N_ALARM);

  // Disabling the channel that is ringing or snoozing silences it.
  assign chan_cleared = alarm_wr && alarm_ok && !alarm_wdata[16] && (alarm_idx == ring_idx_q);

  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : calendar_inc
    logic ss_wrap, mm_wrap, hh_wrap, dd_wrap, mo_wrap;
    ss_wrap   = (time_q[7:0] == 8'h59);
    mm_wrap   = (time_q[15:8] == 8'h59);
    hh_wrap   = (time_q[23:16] == 8'h23);
    dd_wrap   = (date_q[7:0] == days_in_month(date_q[23:16], date_q[15:8]));
    mo_wrap   = (date_q[15:8] == 8'h12);
    day_carry = ss_wrap && mm_wrap && hh_wrap;
    time_inc[7:0]   = ss_wrap ? 8'h00 : bcd_inc(time_q[7:0]);
    time_inc[15:8]  = !ss_wrap ? time_q[15:8] : (mm_wrap ? 8'h00 : bcd_inc(time_q[15:8]));
    time_inc[23:16] = !(ss_wrap && mm_wrap) ? time_q[23:16] :
                      (hh_wrap ? 8'h00 : bcd_inc(time_q[23:16]));
    date_inc[7:0]   = dd_wrap ? 8'h01 : bcd_inc(date_q[7:0]);
    date_inc[15:8]  = !dd_wrap ? date_q[15:8] : (mo_wrap ? 8'h01 : bcd_inc(date_q[15:8]));
    date_inc[23:16] = !(dd_wrap && mo_wrap) ? date_q[23:16] :
                      ((date_q[23:16] == 8'h99) ? 8'h00 : bcd_inc(date_q[23:16]));
  end

  always_comb begin : clock_next
    presc_d     = tick ? '0 : presc_q + PW'(1);
    time_d      = time_q;
    date_d      = date_q;
    sec_pulse_d = 1'b0;
    if (tick) begin
      time_d      = time_inc;
      sec_pulse_d = 1'b1;
      if (day_carry) date_d = date_inc;
    end
    // A time load swallows a coincident increment whole, date carry included.
    if (load_time && time_ok) begin
      time_d      = time_wdata;
      date_d      = date_q;
      presc_d     = '0;
      sec_pulse_d = 1'b0;
    end
    if (load_date && date_ok) date_d = date_wdata;
  end

  always_comb begin : alarm_next
    alarm_en_d = alarm_en_q;
    alarm_hm_d = alarm_hm_q;
    for (int k = 0; k < N_ALARM; k++) begin
      if (alarm_wr && alarm_ok && (alarm_idx == AW'(k))) begin
        alarm_en_d[k] = alarm_wdata[16];
        alarm_hm_d[k] = alarm_wdata[15:0];
      end
    end
  end

  // Scan from the top so the lowest matching channel is the last one written.
  always_comb begin : match_find
    match_hit = 1'b0;
    match_idx = '0;
    if (sec_pulse_q && (time_q[7:0] == 8'h00)) begin
      for (int k = N_ALARM - 1; k >= 0; k--) begin
        if (alarm_en_q[k] && (alarm_hm_q[k] == time_q[23:8])) begin
          match_hit = 1'b1;
          match_idx = AW'(k);
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    sec_cnt_d  = sec_pulse_q ? sec_cnt_q + 14'd1 : sec_cnt_q;
    case (state_q)
      ST_IDLE: begin
        sec_cnt_d = '0;
        if (match_hit) begin
          state_d    = ST_RING;
          ring_idx_d = match_idx;
        end
      end
      ST_RING: begin
        if (ack) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d   = ST_SNOOZE;
          sec_cnt_d = '0;
        end else if (sec_pulse_q && (sec_cnt_q == RING_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end else if (sec_pulse_q && (sec_cnt_q == SNOOZE_LAST)) begin
          state_d   = ST_RING;
          sec_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && chan_cleared) state_d = ST_IDLE;
  end

  always_comb begin : fsm_out
    ring     = (state_q == ST_RING);
    snoozing = (state_q == ST_SNOOZE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      time_q      <= 24'h00_00_00;
      date_q      <= 24'h00_01_01;
      sec_pulse_q <= 1'b0;
      alarm_en_q  <= '0;
      // NOTE: the alarm table is reset on purpose: channels must come up
      // disabled, and a small register file costs little to clear.
      for (int k = 0; k < N_ALARM; k++) alarm_hm_q[k] <= '0;
      state_q     <= ST_IDLE;
      ring_idx_q  <= '0;
      sec_cnt_q   <= '0;
    end else begin
      presc_q     <= presc_d;
      time_q      <= time_d;
      date_q      <= date_d;
      sec_pulse_q <= sec_pulse_d;
      alarm_en_q  <= alarm_en_d;
      alarm_hm_q  <= alarm_hm_d;
      state_q     <= state_d;
      ring_idx_q  <= ring_idx_d;
      sec_cnt_q   <= sec_cnt_d;
    end
  end

  assign time_num  = time_q;
  assign date_num  = date_q;
  assign sec_pulse = sec_pulse_q;
  assign ring_idx  = ring_idx_q;

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Self-checking bench for rtc_alarm_core with a 4-clock second, 3 s ring
// timeout and 1 min snooze. Load validation runs from a vector table; the
// calendar, alarm and ring/snooze corner cases run as directed sequences.
module tb_rtc_alarm_core;
  localparam int CLK_FREQ   = 4;
  localparam int N_ALARM    = 4;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_MIN = 1;
  localparam int AW         = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_time = 1'b0;
  logic [23:0]   time_wdata = '0;
  logic          load_date = 1'b0;
  logic [23:0]   date_wdata = '0;
  logic          alarm_wr = 1'b0;
  logic [AW-1:0] alarm_idx = '0;
  logic [16:0]   alarm_wdata = '0;
  logic          ack = 1'b0;
  logic          snooze = 1'b0;
  logic [23:0]   time_num, date_num;
  logic          sec_pulse, ring, snoozing;
  logic [AW-1:0] ring_idx;

  rtc_alarm_core #(
    .CLK_FREQ(CLK_FREQ), .N_ALARM(N_ALARM), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_time(load_time), .time_wdata(time_wdata),
    .load_date(load_date), .date_wdata(date_wdata),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_wdata(alarm_wdata),
    .ack(ack), .snooze(snooze),
    .time_num(time_num), .date_num(date_num), .sec_pulse(sec_pulse),
    .ring(ring), .snoozing(snoozing), .ring_idx(ring_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load_time(input logic [23:0] t);
    time_wdata = t;
    load_time  = 1'b1;
    step(1);
    load_time  = 1'b0;
  endtask

  task automatic do_load_both(input logic [23:0] t, input logic [23:0] d);
    time_wdata = t;
    date_wdata = d;
    load_time  = 1'b1;
    load_date  = 1'b1;
    step(1);
    load_time  = 1'b0;
    load_date  = 1'b0;
  endtask

  task automatic do_alarm(input logic [AW-1:0] idx, input logic [16:0] v);
    alarm_idx   = idx;
    alarm_wdata = v;
    alarm_wr    = 1'b1;
    step(1);
    alarm_wr    = 1'b0;
  endtask

  typedef struct {
    logic        lt;
    logic [23:0] tw;
    logic        ld;
    logic [23:0] dw;
    logic [23:0] exp_t;
    logic [23:0] exp_d;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_edges;

    // Each vector follows a base load of 12:00:00, so date-only and rejected
    // time loads leave 12:00:00; dates carry over from earlier vectors.
    vecs[0]  = '{1'b1, 24'h235959, 1'b0, 24'h000000, 24'h235959, 24'h000101};
    vecs[1]  = '{1'b1, 24'h240000, 1'b0, 24'h000000, 24'h120000, 24'h000101};
    vecs[2]  = '{1'b1, 24'h126000, 1'b0, 24'h000000, 24'h120000, 24'h000101};
    vecs[3]  = '{1'b1, 24'h120060, 1'b0, 24'h000000, 24'h120000, 24'h000101};
    vecs[4]  = '{1'b1, 24'h0A0000, 1'b0, 24'h000000, 24'h120000, 24'h000101};
    vecs[5]  = '{1'b1, 24'h000000, 1'b0, 24'h000000, 24'h000000, 24'h000101};
    vecs[6]  = '{1'b0, 24'h000000, 1'b1, 24'h240229, 24'h120000, 24'h240229};
    vecs[7]  = '{1'b0, 24'h000000, 1'b1, 24'h230229, 24'h120000, 24'h240229};
    vecs[8]  = '{1'b0, 24'h000000, 1'b1, 24'h231301, 24'h120000, 24'h240229};
    vecs[9]  = '{1'b0, 24'h000000, 1'b1, 24'h230010, 24'h120000, 24'h240229};
    vecs[10] = '{1'b0, 24'h000000, 1'b1, 24'h230431, 24'h120000, 24'h240229};
    vecs[11] = '{1'b0, 24'h000000, 1'b1, 24'h230430, 24'h120000, 24'h230430};
    vecs[12] = '{1'b0, 24'h000000, 1'b1, 24'h000229, 24'h120000, 24'h000229};
    vecs[13] = '{1'b0, 24'h000000, 1'b1, 24'h231200, 24'h120000, 24'h000229};
    vecs[14] = '{1'b1, 24'h083015, 1'b1, 24'h991231, 24'h083015, 24'h991231};
    vecs[15] = '{1'b0, 24'h000000, 1'b1, 24'h23010A, 24'h120000, 24'h991231};

    // Reset values
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset time_num", 32'(time_num), 'h000000);
    check("reset date_num", 32'(date_num), 'h000101);
    check("reset sec_pulse", 32'(sec_pulse), 0);
    check("reset ring", 32'(ring), 0);
    check("reset snoozing", 32'(snoozing), 0);
    check("reset ring_idx", 32'(ring_idx), 0);

    // Load validation table
    for (int i = 0; i < 16; i++) begin
      do_load_time(24'h120000);
      time_wdata = vecs[i].tw;
      date_wdata = vecs[i].dw;
      load_time  = vecs[i].lt;
      load_date  = vecs[i].ld;
      step(1);
      load_time  = 1'b0;
      load_date  = 1'b0;
      check($sformatf("vec%0d time_num", i), 32'(time_num), 32'(vecs[i].exp_t));
      check($sformatf("vec%0d date_num", i), 32'(date_num), 32'(vecs[i].exp_d));
    end

    // Full carry chain: one sec_pulse every 4 clocks
    do_load_both(24'h235958, 24'h231231);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check($sformatf("carry sec_pulse cycle %0d", i), 32'(sec_pulse), (i % 4 == 0) ? 1 : 0);
      if (i == 4) check("carry time at first pulse", 32'(time_num), 'h235959);
    end
    check("carry time_num", 32'(time_num), 'h000000);
    check("carry date_num", 32'(date_num), 'h240101);

    // Leap and non-leap February
    do_load_both(24'h235959, 24'h240228);
    step(4);
    check("leap 24-02-28 rollover", 32'(date_num), 'h240229);
    do_load_both(24'h235959, 24'h230228);
    step(4);
    check("non-leap 23-02-28 rollover", 32'(date_num), 'h230301);
    check("non-leap rollover time", 32'(time_num), 'h000000);

    // Load on a terminal-count edge wins and drops the increment
    do_load_time(24'h100000);
    step(3);
    do_load_time(24'h111111);
    check("conflict loaded time", 32'(time_num), 'h111111);
    check("conflict no sec_pulse", 32'(sec_pulse), 0);
    step(4);
    check("conflict next second", 32'(time_num), 'h111112);
    check("conflict next sec_pulse", 32'(sec_pulse), 1);

    // Multi-alarm priority and match discarded while ringing
    do_alarm(2'd1, {1'b1, 16'h0700});
    do_alarm(2'd2, {1'b1, 16'h0700});
    do_alarm(2'd3, {1'b1, 16'h0702});
    do_load_time(24'h065959);
    step(4);
    check("prio match cycle time", 32'(time_num), 'h070000);
    check("prio ring not yet", 32'(ring), 0);
    step(1);
    check("prio ring", 32'(ring), 1);
    check("prio ring_idx", 32'(ring_idx), 1);
    do_load_time(24'h070159);
    step(4);
    check("ch3 match time", 32'(time_num), 'h070200);
    step(1);
    check("ch3 ignored ring", 32'(ring), 1);
    check("ch3 ignored ring_idx", 32'(ring_idx), 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("ack stops ring", 32'(ring), 0);

    // Auto timeout after RING_SEC sec_pulses
    do_load_time(24'h065959);
    step(5);
    check("timeout ring start", 32'(ring), 1);
    step(11);
    check("timeout ring before 3rd pulse edge", 32'(ring), 1);
    step(1);
    check("timeout ring dropped", 32'(ring), 0);

    // ack and snooze on the same edge: ack wins
    do_load_time(24'h065959);
    step(5);
    check("ack+snooze ring start", 32'(ring), 1);
    ack    = 1'b1;
    snooze = 1'b1;
    step(1);
    ack    = 1'b0;
    snooze = 1'b0;
    check("ack+snooze ring", 32'(ring), 0);
    check("ack+snooze snoozing", 32'(snoozing), 0);

    // Snooze lasts 60 sec_pulses, then rings again on the same channel
    do_load_time(24'h065959);
    step(5);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    check("snooze entered", 32'(snoozing), 1);
    check("snooze ring low", 32'(ring), 0);
    n_edges = 0;
    for (int i = 1; i <= 300; i++) begin
      step(1);
      if (i == 238) check("snooze held before expiry", 32'(snoozing), 1);
      if (ring) begin
        n_edges = i;
        break;
      end
    end
    check("snooze length in edges", 32'(n_edges), 239);
    check("snooze re-ring ring_idx", 32'(ring_idx), 1);

    // Disabling the snoozing channel; an invalid write is ignored first
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    check("disable: snoozing again", 32'(snoozing), 1);
    do_alarm(2'd1, {1'b0, 16'h2400});
    check("invalid disable ignored", 32'(snoozing), 1);
    do_alarm(2'd1, {1'b0, 16'h0700});
    check("disable returns idle", 32'(snoozing), 0);
    check("disable ring low", 32'(ring), 0);

    // Asynchronous reset mid-ring
    do_alarm(2'd1, {1'b1, 16'h0700});
    do_load_time(24'h065959);
    step(5);
    check("pre-reset ring", 32'(ring), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset ring", 32'(ring), 0);
    check("async reset ring_idx", 32'(ring_idx), 0);
    check("async reset time_num", 32'(time_num), 'h000000);
    check("async reset date_num", 32'(date_num), 'h000101);
    check("async reset snoozing", 32'(snoozing), 0);
    check("async reset sec_pulse", 32'(sec_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load_time(24'h065959);
    step(4);
    check("post-reset time", 32'(time_num), 'h070000);
    step(1);
    check("post-reset alarms disabled", 32'(ring), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
